// File: rtl/vga_char_mover.sv
// vga_char_mover: frame-synchronous sequencer for the origin and foreground
// colour of the character block drawn by the VGA picture generator.
// Once every FRAME_DIV frames, during vertical blanking, the block moves by
// `step` pixels on each axis and bounces off the screen edges. Every update
// that bounces also advances the foreground colour.
// Optional feature macro: VGA_CHAR_BLINK_EN. When it is defined, char_show
// toggles every BLINK_TICKS frame ticks. Otherwise char_show is tied high.
module vga_char_mover #(
    parameter int H_VALID   = 640,
    parameter int V_VALID   = 480,
    parameter int CHAR_W    = 256,
    parameter int CHAR_H    = 64,
    parameter int INIT_H    = 192,
    parameter int INIT_V    = 208,
    parameter int FRAME_DIV = 1
`ifdef VGA_CHAR_BLINK_EN
    ,
    parameter int BLINK_TICKS = 30
`endif
) (
    input  logic        vga_clk,
    input  logic        sys_rst_n,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    input  logic        run,
    input  logic [3:0]  step,
    output logic [9:0]  char_b_h,
    output logic [9:0]  char_b_v,
    output logic [15:0] fg_color,
    output logic        frame_tick,
    output logic [7:0]  bounce_cnt,
    output logic        char_show
);

    localparam logic [9:0] LIM_H   = 10'(H_VALID - CHAR_W);
    localparam logic [9:0] LIM_V   = 10'(V_VALID - CHAR_H);
    localparam logic [7:0] DIV_TOP = 8'(FRAME_DIV - 1);

    typedef enum logic [2:0] {IDLE, WAIT_EOF, MOVE_H, MOVE_V, DONE} state_t;

    state_t      state_reg, state_next;
    logic        at_last, at_last_reg, eof_reg, due;
    logic [7:0]  div_reg;
    logic [3:0]  step_reg;
    logic [9:0]  h_reg, v_reg;
    logic        dir_h_reg, dir_v_reg;     // 1 = right / down
    logic        bounce_h_reg, bounce_v_reg;
    logic [1:0]  color_idx_reg;
    logic [7:0]  bounce_cnt_reg;
    logic [11:0] h_step, v_step;           // {bounce, new_dir, new_pos}

    // One axis move: 11-bit sum so that a far overshoot cannot wrap.
    function automatic logic [11:0] axis_next(input logic [9:0] cur, input logic fwd,
                                              input logic [3:0] stp, input logic [9:0] lim);
        logic [10:0] sum;
        logic [11:0] res;
        sum = {1'b0, cur} + {7'b0, stp};
        res = {1'b0, fwd, cur};
        if (stp != 4'd0) begin
            if (fwd) begin
                if (sum >= {1'b0, lim}) res = {1'b1, 1'b0, lim};
                else                    res = {1'b0, 1'b1, sum[9:0]};
            end else begin
                if ({1'b0, cur} <= {7'b0, stp}) res = {1'b1, 1'b1, 10'd0};
                else                            res = {1'b0, 1'b0, cur - {6'b0, stp}};
            end
        end
        return res;
    endfunction

    assign at_last = (pix_x == 10'(H_VALID - 1)) && (pix_y == 10'(V_VALID - 1));
    assign due     = eof_reg && (div_reg == DIV_TOP);
    assign h_step  = axis_next(h_reg, dir_h_reg, step_reg, LIM_H);
    assign v_step  = axis_next(v_reg, dir_v_reg, step_reg, LIM_V);

    // Edge-detect the last active pixel so that each frame yields exactly one EOF pulse.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            at_last_reg <= 1'b0;
            eof_reg     <= 1'b0;
        end else begin
            at_last_reg <= at_last;
            eof_reg     <= at_last & ~at_last_reg;
        end
    end

    // Frame divider: counts EOFs only while the FSM is active, and holds in IDLE.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)                      div_reg <= 8'd0;
        else if (eof_reg && state_reg != IDLE) div_reg <= due ? 8'd0 : div_reg + 8'd1;
    end

    // FSM state register.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state_reg <= IDLE;
        else            state_reg <= state_next;
    end

    // Next-state logic. A due EOF wins over a simultaneous drop of run.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:     if (run) state_next = WAIT_EOF;
            WAIT_EOF: begin
                if (due)       state_next = MOVE_H;
                else if (!run) state_next = IDLE;
            end
            MOVE_H:   state_next = MOVE_V;
            MOVE_V:   state_next = DONE;
            DONE:     state_next = run ? WAIT_EOF : IDLE;
            default:  state_next = IDLE;
        endcase
    end

    assign frame_tick = (state_reg == DONE);

    // Datapath: latch step, move each axis in its own cycle, then apply the colour and bounce count.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            step_reg       <= 4'd0;
            h_reg          <= 10'(INIT_H);
            v_reg          <= 10'(INIT_V);
            dir_h_reg      <= 1'b1;
            dir_v_reg      <= 1'b1;
            bounce_h_reg   <= 1'b0;
            bounce_v_reg   <= 1'b0;
            color_idx_reg  <= 2'd0;
            bounce_cnt_reg <= 8'd0;
        end else begin
            case (state_reg)
                WAIT_EOF: if (due) step_reg <= step;
                MOVE_H: begin
                    h_reg        <= h_step[9:0];
                    dir_h_reg    <= h_step[10];
                    bounce_h_reg <= h_step[11];
                end
                MOVE_V: begin
                    v_reg        <= v_step[9:0];
                    dir_v_reg    <= v_step[10];
                    bounce_v_reg <= v_step[11];
                end
                DONE: begin
                    if (bounce_h_reg || bounce_v_reg) begin
                        color_idx_reg <= color_idx_reg + 2'd1;
                        if (bounce_cnt_reg != 8'hFF) bounce_cnt_reg <= bounce_cnt_reg + 8'd1;
                    end
                    bounce_h_reg <= 1'b0;
                    bounce_v_reg <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Palette lookup: FEC0 -> FFFF -> F800 -> 07E0 -> FEC0.
    always_comb begin
        fg_color = 16'hFEC0;
        case (color_idx_reg)
            2'd0: fg_color = 16'hFEC0;
            2'd1: fg_color = 16'hFFFF;
            2'd2: fg_color = 16'hF800;
            2'd3: fg_color = 16'h07E0;
            default: fg_color = 16'hFEC0;
        endcase
    end

    assign char_b_h   = h_reg;
    assign char_b_v   = v_reg;
    assign bounce_cnt = bounce_cnt_reg;

`ifdef VGA_CHAR_BLINK_EN
    logic [15:0] blink_cnt_reg;
    logic        show_reg;

    // Blink counter advances on frame ticks only, so it holds naturally while IDLE.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            blink_cnt_reg <= 16'd0;
            show_reg      <= 1'b1;
        end else if (frame_tick) begin
            if (blink_cnt_reg == 16'(BLINK_TICKS - 1)) begin
                blink_cnt_reg <= 16'd0;
                show_reg      <= ~show_reg;
            end else begin
                blink_cnt_reg <= blink_cnt_reg + 16'd1;
            end
        end
    end

    assign char_show = show_reg;
`else
    assign char_show = 1'b1;
`endif

endmodule

// File: tb/tb_vga_char_mover.sv
// Testbench for vga_char_mover. Frames are compressed so that the last-pixel
// coordinate is presented for one cycle, followed by a few blanking cycles.
// The bench drives two instances, with FRAME_DIV=1 and FRAME_DIV=3, and checks
// them against a frame-level reference model.
module tb_vga_char_mover;

`ifdef VGA_CHAR_BLINK_EN
    localparam int BT = 2;
`endif

    logic        clk = 1'b0;
    logic        sys_rst_n;
    logic [9:0]  pix_x, pix_y;
    logic        run;
    logic [3:0]  step;
    logic [9:0]  h1, v1, h3, v3;
    logic [15:0] col1, col3;
    logic        ft1, ft3, show1, show3;
    logic [7:0]  bc1, bc3;

    int checks = 0;
    int failures = 0;
    int tick_obs[2] = '{0, 0};
    int tick_base[2];

    // Reference model state, one entry per instance.
    int m_h[2], m_v[2], m_dh[2], m_dv[2], m_col[2], m_bcnt[2], m_div[2], m_ticks[2];
    int m_fd[2] = '{1, 3};
    logic [15:0] palette[4] = '{16'hFEC0, 16'hFFFF, 16'hF800, 16'h07E0};

    always #5 clk = ~clk;

    vga_char_mover #(
        .FRAME_DIV(1)
`ifdef VGA_CHAR_BLINK_EN
        , .BLINK_TICKS(BT)
`endif
    ) dut1 (
        .vga_clk(clk), .sys_rst_n(sys_rst_n), .pix_x(pix_x), .pix_y(pix_y),
        .run(run), .step(step), .char_b_h(h1), .char_b_v(v1), .fg_color(col1),
        .frame_tick(ft1), .bounce_cnt(bc1), .char_show(show1)
    );

    vga_char_mover #(
        .FRAME_DIV(3)
`ifdef VGA_CHAR_BLINK_EN
        , .BLINK_TICKS(BT)
`endif
    ) dut3 (
        .vga_clk(clk), .sys_rst_n(sys_rst_n), .pix_x(pix_x), .pix_y(pix_y),
        .run(run), .step(step), .char_b_h(h3), .char_b_v(v3), .fg_color(col3),
        .frame_tick(ft3), .bounce_cnt(bc3), .char_show(show3)
    );

    always @(negedge clk) begin
        if (ft1 === 1'b1) tick_obs[0] <= tick_obs[0] + 1;
        if (ft3 === 1'b1) tick_obs[1] <= tick_obs[1] + 1;
    end

    initial begin
        #1000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_h[i] = 192; m_v[i] = 208; m_dh[i] = 1; m_dv[i] = 1;
            m_col[i] = 0; m_bcnt[i] = 0; m_div[i] = 0; m_ticks[i] = 0;
        end
    endtask

    // Moves one coordinate on the 0..lim line and reports whether it hit an edge.
    task automatic move_axis(inout int pos, inout int dir, input int s, input int lim, output bit hit);
        hit = 0;
        if (s == 0) return;
        if (dir == 1) begin
            if (pos + s >= lim) begin pos = lim; dir = 0; hit = 1; end
            else pos = pos + s;
        end else begin
            if (pos <= s) begin pos = 0; dir = 1; hit = 1; end
            else pos = pos - s;
        end
    endtask

    task automatic model_frame(input int i, input bit runb, input int s, output bit upd);
        bit hh, hv;
        upd = 0;
        if (!runb) return;
        m_div[i] = (m_div[i] + 1) % m_fd[i];
        if (m_div[i] != 0) return;
        upd = 1;
        m_ticks[i]++;
        move_axis(m_h[i], m_dh[i], s, 640 - 256, hh);
        move_axis(m_v[i], m_dv[i], s, 480 - 64, hv);
        if (hh || hv) begin
            m_col[i] = (m_col[i] + 1) % 4;
            m_bcnt[i] = (m_bcnt[i] < 255) ? m_bcnt[i] + 1 : 255;
        end
    endtask

    function automatic logic exp_show(input int i);
`ifdef VGA_CHAR_BLINK_EN
        return ((m_ticks[i] / BT) % 2 == 0);
`else
        return (i >= 0);
`endif
    endfunction

    task automatic check_all(input string tag);
        check({tag, "_h1"}, h1, m_h[0]);
        check({tag, "_v1"}, v1, m_v[0]);
        check({tag, "_col1"}, col1, palette[m_col[0]]);
        check({tag, "_bcnt1"}, bc1, m_bcnt[0]);
        check({tag, "_ticks1"}, tick_obs[0] - tick_base[0], m_ticks[0]);
        check({tag, "_show1"}, show1, exp_show(0));
        check({tag, "_h3"}, h3, m_h[1]);
        check({tag, "_v3"}, v3, m_v[1]);
        check({tag, "_col3"}, col3, palette[m_col[1]]);
        check({tag, "_bcnt3"}, bc3, m_bcnt[1]);
        check({tag, "_ticks3"}, tick_obs[1] - tick_base[1], m_ticks[1]);
        check({tag, "_show3"}, show3, exp_show(1));
    endtask

    // One compressed frame. With timing set, the FRAME_DIV=1 instance is also
    // checked cycle by cycle just after the EOF.
    task automatic do_frame(input string tag, input bit runb, input int s, input bit timing, input bit drop);
        bit u1, u3;
        int ov;
        @(negedge clk); run = runb; step = 4'(s);
        repeat (2) @(negedge clk);
        ov = m_v[0];
        model_frame(0, runb, s, u1);
        model_frame(1, runb, s, u3);
        pix_x = 10'd639; pix_y = 10'd479;
        @(negedge clk); pix_x = 10'h3FF; pix_y = 10'h3FF;
        @(negedge clk);
        @(negedge clk);
        if (timing) begin
            check({tag, "_h_at2"}, h1, m_h[0]);
            check({tag, "_v_hold_at2"}, v1, ov);
        end
        if (drop) run = 1'b0;
        @(negedge clk);
        if (timing) begin
            check({tag, "_v_at3"}, v1, m_v[0]);
            check({tag, "_tick_at3"}, ft1, u1);
        end
        @(negedge clk);
        if (timing) check({tag, "_tick_clear"}, ft1, 1'b0);
        repeat (3) @(negedge clk);
        check_all(tag);
        $display("frame %s run=%0d step=%0d h=%0d v=%0d col=%h bcnt=%0d", tag, runb, s, h1, v1, col1, bc1);
    endtask

    initial begin
        int s, dh, dv;
        bit rb, dr;
        int hold_h;
        sys_rst_n = 1'b0; run = 1'b0; step = 4'd0;
        pix_x = 10'h3FF; pix_y = 10'h3FF;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_h", h1, 10'd192);
        check("rst_v", v1, 10'd208);
        check("rst_col", col1, 16'hFEC0);
        check("rst_bcnt", bc1, 8'd0);
        check("rst_tick", ft1, 1'b0);
        check("rst_show", show1, 1'b1);
        tick_base[0] = tick_obs[0]; tick_base[1] = tick_obs[1];
        sys_rst_n = 1'b1;

        // Basic move.
        do_frame("basic", 1, 4, 1, 0);
        check("basic_h196", h1, 10'd196);
        check("basic_v212", v1, 10'd212);

        // Approach the right edge and bounce.
        for (int k = 0; k < 93; k++) do_frame("walk", 1, 2, 0, 0);
        check("walk_h382", h1, 10'd382);
        do_frame("rbounce", 1, 4, 1, 0);
        check("rbounce_h384", h1, 10'd384);
        check("rbounce_col", col1, 16'hFFFF);
        check("rbounce_cnt", bc1, 8'd1);
        do_frame("rback", 1, 4, 1, 0);
        check("rback_h380", h1, 10'd380);

        // Drop run during MOVE_V: the update completes, then motion stops.
        do_frame("drop", 1, 3, 1, 1);
        hold_h = m_h[0];
        for (int k = 0; k < 5; k++) do_frame("idle", 0, 5, 1, 0);
        check("idle_h_hold", h1, hold_h);

        // A zero step holds the origin while ticks continue.
        for (int k = 0; k < 4; k++) do_frame("step0", 1, 0, 1, 0);

        // Randomized frames, with a bias toward corner hits when both edges are near.
        for (int k = 0; k < 150; k++) begin
            rb = ($urandom_range(0, 9) != 0);
            s  = $urandom_range(0, 15);
            dh = (m_dh[0] == 1) ? 384 - m_h[0] : m_h[0];
            dv = (m_dv[0] == 1) ? 416 - m_v[0] : m_v[0];
            if (dh <= 15 && dv <= 15) s = 15;
            dr = rb && ($urandom_range(0, 15) == 0);
            do_frame("rand", rb, s, 1, dr);
        end

        // Asynchronous reset asserted in the middle of a move sequence.
        @(negedge clk); run = 1'b1; step = 4'd7;
        repeat (2) @(negedge clk);
        pix_x = 10'd639; pix_y = 10'd479;
        @(negedge clk); pix_x = 10'h3FF; pix_y = 10'h3FF;
        @(negedge clk);
        #2 sys_rst_n = 1'b0; run = 1'b0;
        #1;
        check("arst_h", h1, 10'd192);
        check("arst_v", v1, 10'd208);
        check("arst_col", col1, 16'hFEC0);
        check("arst_bcnt", bc1, 8'd0);
        check("arst_tick", ft1, 1'b0);
        check("arst_show", show1, 1'b1);
        @(negedge clk);
        model_reset();
        tick_base[0] = tick_obs[0]; tick_base[1] = tick_obs[1];
        sys_rst_n = 1'b1;
        do_frame("post_rst", 1, 4, 1, 0);
        check("post_rst_h196", h1, 10'd196);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_char_mover.md
Name: vga_char_mover

Overview:
- Frame-synchronous controller that sequences the position and colour of the 256x64 character block drawn by the VGA picture generator.
- Once per N frames, during vertical blanking, advances the block origin (bouncing off the screen edges) and cycles the foreground colour on each bounce.
- Outputs feed the picture generator's origin and colour inputs directly, replacing its fixed constants.

Parameters:
- H_VALID, 640, active pixels per line.
- V_VALID, 480, active lines per frame.
- CHAR_W, 256, block width in pixels.
- CHAR_H, 64, block height in lines.
- INIT_H, 192, reset horizontal origin.
- INIT_V, 208, reset vertical origin.
- FRAME_DIV, 1, number of end-of-frame events per position update (range 1..255).

Ports:
- vga_clk  in  1  pixel clock
- sys_rst_n  in  1  reset
- pix_x  in  10  current pixel column from the VGA timing block (10'h3FF outside active area)
- pix_y  in  10  current pixel row (10'h3FF outside active area)
- run  in  1  level enable for motion
- step  in  4  pixels moved per update on each axis
- char_b_h  out  10  block horizontal origin
- char_b_v  out  10  block vertical origin
- fg_color  out  16  RGB565 foreground colour
- frame_tick  out  1  one-cycle pulse when an update completes
- bounce_cnt  out  8  saturating count of bounce events

Interface: reset sys_rst_n, asynchronous, active-low; clock vga_clk.

Behaviour:
- Reset values:
  - char_b_h=INIT_H, char_b_v=INIT_V
  - dir_h=right, dir_v=down
  - fg_color=16'hFEC0
  - frame_tick=0, bounce_cnt=0
  - frame divider=0, state=IDLE
- EOF event:
  - Raised in the cycle after pix_x==H_VALID-1 && pix_y==V_VALID-1 first becomes true (edge-detected).
  - Produces exactly one event per frame.
- Frame divider counts EOF events 0..FRAME_DIV-1. An update is due on the EOF that wraps the counter to 0. The divider counts only while state!=IDLE.
- FSM states: IDLE, WAIT_EOF, MOVE_H, MOVE_V, DONE.
  - IDLE -> WAIT_EOF when run=1.
  - WAIT_EOF -> MOVE_H on a due EOF; step is latched into step_q on this transition.
  - WAIT_EOF -> IDLE if run=0.
  - MOVE_H -> MOVE_V -> DONE unconditionally, one cycle each.
  - DONE asserts frame_tick for one cycle, then goes to WAIT_EOF if run=1, else IDLE.
- Timing: char_b_h updates 2 cycles after the EOF event and char_b_v 3 cycles after. Both land well inside vertical blanking, so no mid-frame tearing.
- Axis arithmetic (11-bit intermediates); LIM_H=H_VALID-CHAR_W (384), LIM_V=V_VALID-CHAR_H (416):
  - Moving right/down: next=cur+step_q. If next>=LIM, origin=LIM, direction flips, and the axis bounce flag is set.
  - Moving left/up: if cur<=step_q, origin=0, direction flips, and the flag is set. Otherwise origin=cur-step_q.
  - step_q=0: origin holds, no bounce flag, frame_tick still pulses.
- Colour/bounce, evaluated in DONE: if either bounce flag is set, fg_color advances one entry and bounce_cnt increments by 1, saturating at 255.
  - Palette order: FEC0 -> FFFF -> F800 -> 07E0 -> FEC0.
  - A corner hit (both axes in one update) counts as one event.
  - Both flags clear in DONE.
- run dropped mid-sequence (MOVE_H/MOVE_V/DONE): the sequence completes, including frame_tick, then the FSM enters IDLE. In IDLE, outputs hold and the divider holds its value.
- Asynchronous reset at any point restores all reset values immediately.

Optional Feature:
- Macro: VGA_CHAR_BLINK_EN
- Defined:
  - Adds output char_show (1 bit, reset 1) and parameter BLINK_TICKS (default 30).
  - A counter of frame_tick pulses toggles char_show when it reaches BLINK_TICKS-1, then wraps to 0.
  - The counter holds while IDLE.
- Undefined: port char_show is still present, tied to 1'b1, with no counter logic.

Test Plan:
- Reset: hold sys_rst_n=0 -> char_b_h=192, char_b_v=208, fg_color=FEC0, bounce_cnt=0, frame_tick=0.
- Basic move: run=1, step=4, FRAME_DIV=1, one frame -> 2/3 cycles after EOF char_b_h=196 then char_b_v=212; exactly one frame_tick pulse per frame.
- Right bounce: origin h=382, dir right, step=4 -> h=384, next frame h=380; fg_color=FFFF, bounce_cnt=1.
- Corner bounce: h=382, v=414, both increasing, step=4 -> h=384, v=416, fg_color advances once, bounce_cnt +1 only.
- Divider and enable: FRAME_DIV=3 -> updates on every 3rd EOF only. Drop run during MOVE_V -> update completes, frame_tick pulses, no further motion over 5 frames. step=0 -> origin constant, ticks continue.
- VGA_CHAR_BLINK_EN defined, BLINK_TICKS=2 -> char_show toggles 1->0->1 every 2 frame_ticks. Undefined -> char_show constant 1.
